// File: rtl/reg_status_file.sv
// Register status file: 32 architectural registers with rename busy/tag tracking,
// ROB commit write-back with tag-matched busy clear, flush, and two 1-cycle lookup ports.
package sched_structs;
    typedef struct packed {
        logic       write;
        logic [4:0] rd;
        logic [4:0] rob_index;
        logic       lookup_regfile_1;
        logic [5:0] reg_idx_1;
        logic       lookup_regfile_2;
        logic [5:0] reg_idx_2;
    } IQtoRF;

    typedef struct packed {
        logic        lookup_valid_1;
        logic        valid_1;
        logic [31:0] val_1;
        logic        lookup_valid_2;
        logic        valid_2;
        logic [31:0] val_2;
    } RFtoIQ;

    typedef struct packed {
        logic        flush_all;
        logic [31:0] target_pc;
    } ROBToALL;
endpackage

module reg_status_file
    import sched_structs::*;
#(
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  IQtoRF       iq_req,
    output RFtoIQ       rf_resp,
    input  ROBToALL     rob_ctrl,
    input  logic        commit_valid,
    input  logic [4:0]  commit_rd,
    input  logic [4:0]  commit_rob,
    input  logic [31:0] commit_val
);

    logic [31:0][31:0] value_reg, value_next;
    logic [31:0]       busy_reg, busy_next;
    logic [31:0][4:0]  tag_reg, tag_next;

    logic rename_en;
    logic commit_en;
    logic flush;

    assign flush     = rob_ctrl.flush_all;
    assign rename_en = iq_req.write && !(ZERO_HARDWIRED && (iq_req.rd == 5'd0));
    assign commit_en = commit_valid && !(ZERO_HARDWIRED && (commit_rd == 5'd0));

    // Rename beats a same-cycle commit clear; flush beats both but never touches values.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_entry
            logic rename_hit;
            logic commit_hit;

            assign rename_hit = rename_en && (iq_req.rd == 5'(gi));
            assign commit_hit = commit_en && (commit_rd == 5'(gi));

            assign value_next[gi] = commit_hit ? commit_val : value_reg[gi];
            assign busy_next[gi]  = flush      ? 1'b0 :
                                    rename_hit ? 1'b1 :
                                    (commit_hit && (tag_reg[gi] == commit_rob)) ? 1'b0 :
                                    busy_reg[gi];
            assign tag_next[gi]   = (!flush && rename_hit) ? iq_req.rob_index : tag_reg[gi];
        end
    endgenerate

    logic [1:0]       lk_en;
    logic [1:0][4:0]  lk_idx;
    logic [1:0]       lkv_next, lkv_reg;
    logic [1:0]       vld_next, vld_reg;
    logic [1:0][31:0] val_next, val_reg;

    assign lk_en  = {iq_req.lookup_regfile_2, iq_req.lookup_regfile_1};
    assign lk_idx = {iq_req.reg_idx_2[4:0], iq_req.reg_idx_1[4:0]};

    // Lookups read pre-edge state, so a same-cycle rename is invisible; a matching
    // same-cycle commit is forwarded directly.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [4:0]  idx;
            logic        port_lkv;
            logic        port_vld;
            logic [31:0] port_val;

            assign idx = lk_idx[gi];

            always_comb begin
                port_lkv = 1'b0;
                port_vld = 1'b0;
                port_val = '0;
                if (lk_en[gi] && !flush) begin
                    port_lkv = 1'b1;
                    if (ZERO_HARDWIRED && (idx == 5'd0)) begin
                        port_vld = 1'b1;
                    end else if (busy_reg[idx]) begin
                        if (commit_en && (commit_rd == idx) && (commit_rob == tag_reg[idx])) begin
                            port_vld = 1'b1;
                            port_val = commit_val;
                        end else begin
                            port_val = {27'b0, tag_reg[idx]};
                        end
                    end else begin
                        port_vld = 1'b1;
                        port_val = value_reg[idx];
                    end
                end
            end

            assign lkv_next[gi] = port_lkv;
            assign vld_next[gi] = port_vld;
            assign val_next[gi] = port_val;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg <= '0;
            busy_reg  <= '0;
            tag_reg   <= '0;
            lkv_reg   <= '0;
            vld_reg   <= '0;
            val_reg   <= '0;
        end else begin
            value_reg <= value_next;
            busy_reg  <= busy_next;
            tag_reg   <= tag_next;
            lkv_reg   <= lkv_next;
            vld_reg   <= vld_next;
            val_reg   <= val_next;
        end
    end

    assign rf_resp.lookup_valid_1 = lkv_reg[0];
    assign rf_resp.valid_1        = vld_reg[0];
    assign rf_resp.val_1          = val_reg[0];
    assign rf_resp.lookup_valid_2 = lkv_reg[1];
    assign rf_resp.valid_2        = vld_reg[1];
    assign rf_resp.val_2          = val_reg[1];

    logic unused_bits;
    assign unused_bits = ^{rob_ctrl.target_pc, iq_req.reg_idx_1[5], iq_req.reg_idx_2[5]};

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios plus randomized traffic
// checked against an array-based behavioural model of the register status rules.
module tb_reg_status_file;
    import sched_structs::*;

    logic        clk = 1'b0;
    logic        rst;
    IQtoRF       iq_req;
    RFtoIQ       rf_resp;
    ROBToALL     rob_ctrl;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [4:0]  commit_rob;
    logic [31:0] commit_val;

    RFtoIQ exp_resp;
    int    tests_run = 0;
    int    tests_failed = 0;

    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [4:0]  m_tag  [32];

    reg_status_file #(.ZERO_HARDWIRED(1'b1)) dut (
        .clk(clk), .rst(rst), .iq_req(iq_req), .rf_resp(rf_resp), .rob_ctrl(rob_ctrl),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rob(commit_rob),
        .commit_val(commit_val)
    );

    always #5 clk = ~clk;

    // Answer a lookup from the architectural view before this cycle's updates.
    function automatic void model_lookup(input logic en, input logic [5:0] ridx,
                                         output logic lv, output logic v, output logic [31:0] d);
        int r;
        r = int'(ridx[4:0]);
        lv = 1'b0; v = 1'b0; d = '0;
        if (rst || !en || rob_ctrl.flush_all) return;
        lv = 1'b1;
        if (r == 0) begin
            v = 1'b1;
        end else if (m_busy[r]) begin
            if (commit_valid && int'(commit_rd) == r && commit_rob == m_tag[r]) begin
                v = 1'b1;
                d = commit_val;
            end else begin
                d = {27'b0, m_tag[r]};
            end
        end else begin
            v = 1'b1;
            d = m_val[r];
        end
    endfunction

    task automatic idle();
        iq_req       = '0;
        rob_ctrl     = '0;
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_rob   = '0;
        commit_val   = '0;
        rst          = 1'b0;
    endtask

    // One clock: predict responses, advance the model, settle past the edge.
    task automatic step();
        logic lv, v;
        logic [31:0] d;
        bit clear_commit;
        model_lookup(iq_req.lookup_regfile_1, iq_req.reg_idx_1, lv, v, d);
        exp_resp.lookup_valid_1 = lv; exp_resp.valid_1 = v; exp_resp.val_1 = d;
        model_lookup(iq_req.lookup_regfile_2, iq_req.reg_idx_2, lv, v, d);
        exp_resp.lookup_valid_2 = lv; exp_resp.valid_2 = v; exp_resp.val_2 = d;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
            end
        end else begin
            clear_commit = 0;
            if (commit_valid && commit_rd != 0) begin
                m_val[commit_rd] = commit_val;
                clear_commit = (m_tag[commit_rd] == commit_rob);
            end
            if (rob_ctrl.flush_all) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (clear_commit) m_busy[commit_rd] = 0;
                if (iq_req.write && iq_req.rd != 0) begin
                    m_busy[iq_req.rd] = 1;
                    m_tag[iq_req.rd]  = iq_req.rob_index;
                end
            end
        end
        #1;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [4:0] rob);
        idle();
        iq_req.write = 1'b1; iq_req.rd = rd; iq_req.rob_index = rob;
        step();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] val);
        idle();
        commit_valid = 1'b1; commit_rd = rd; commit_rob = rob; commit_val = val;
        step();
    endtask

    task automatic do_lookup(input logic [5:0] r1, input logic [5:0] r2);
        idle();
        iq_req.lookup_regfile_1 = 1'b1; iq_req.reg_idx_1 = r1;
        iq_req.lookup_regfile_2 = 1'b1; iq_req.reg_idx_2 = r2;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        iq_req = IQtoRF'({$urandom, $urandom});
        commit_valid = 1'b1; commit_rd = 5'd9; commit_rob = 5'd1; commit_val = $urandom;
        step();
        step();
        tests_run++;
        if (rf_resp !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_resp: got %h expected 0", rf_resp);
        end
        do_lookup(6'd5, 6'd17);
        tests_run++;
        if ({rf_resp.lookup_valid_1, rf_resp.valid_1, rf_resp.val_1} !== {2'b11, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_lookup_x5: got %b/%b/%h expected 1/1/0",
                     rf_resp.lookup_valid_1, rf_resp.valid_1, rf_resp.val_1);
        end
    endtask

    task automatic test_rename_lookup();
        do_rename(5'd3, 5'd7);
        do_lookup(6'd3, 6'd4);
        tests_run++;
        if (rf_resp.valid_1 !== 1'b0 || rf_resp.val_1 !== 32'd7 || rf_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL rename_lookup: got %h expected %h (valid 0 val 7)", rf_resp, exp_resp);
        end
    endtask

    task automatic test_commit();
        do_commit(5'd3, 5'd7, 32'hDEADBEEF);
        do_lookup(6'd3, 6'd35);
        tests_run++;
        if (rf_resp.valid_1 !== 1'b1 || rf_resp.val_1 !== 32'hDEADBEEF || rf_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL commit_lookup: got %h expected %h", rf_resp, exp_resp);
        end
    endtask

    task automatic test_stale_commit();
        do_rename(5'd3, 5'd7);
        do_rename(5'd3, 5'd9);
        do_commit(5'd3, 5'd7, 32'h11);
        do_lookup(6'd0, 6'd3);
        tests_run++;
        if (rf_resp.valid_2 !== 1'b0 || rf_resp.val_2 !== 32'd9 || rf_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL stale_commit: got %h expected %h (valid 0 val 9)", rf_resp, exp_resp);
        end
    endtask

    task automatic test_flush();
        do_rename(5'd4, 5'd5);
        do_commit(5'd4, 5'd5, 32'h0000A5A5);
        do_rename(5'd3, 5'd2);
        do_rename(5'd4, 5'd6);
        idle();
        iq_req.lookup_regfile_1 = 1'b1; iq_req.reg_idx_1 = 6'd3;
        iq_req.lookup_regfile_2 = 1'b1; iq_req.reg_idx_2 = 6'd4;
        iq_req.write = 1'b1; iq_req.rd = 5'd10; iq_req.rob_index = 5'd12;
        commit_valid = 1'b1; commit_rd = 5'd3; commit_rob = 5'd2; commit_val = 32'h22;
        rob_ctrl.flush_all = 1'b1;
        step();
        tests_run++;
        if (rf_resp.lookup_valid_1 !== 1'b0 || rf_resp.lookup_valid_2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_lookup: got lv1=%b lv2=%b expected 0/0",
                     rf_resp.lookup_valid_1, rf_resp.lookup_valid_2);
        end
        do_lookup(6'd3, 6'd4);
        tests_run++;
        if ({rf_resp.valid_1, rf_resp.val_1, rf_resp.valid_2, rf_resp.val_2} !==
            {1'b1, 32'h22, 1'b1, 32'h0000A5A5}) begin
            tests_failed++;
            $display("FAIL flush_values: got %h expected x3=1/22 x4=1/a5a5", rf_resp);
        end
        do_lookup(6'd10, 6'd10);
        tests_run++;
        if (rf_resp.valid_1 !== 1'b1 || rf_resp.val_1 !== 32'h0 || rf_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL flush_drops_rename: got %h expected %h", rf_resp, exp_resp);
        end
    endtask

    task automatic test_x0();
        idle();
        iq_req.write = 1'b1; iq_req.rd = 5'd0; iq_req.rob_index = 5'd3;
        commit_valid = 1'b1; commit_rd = 5'd0; commit_rob = 5'd3; commit_val = 32'h55;
        iq_req.lookup_regfile_1 = 1'b1; iq_req.reg_idx_1 = 6'd0;
        iq_req.lookup_regfile_2 = 1'b1; iq_req.reg_idx_2 = 6'd32;
        step();
        tests_run++;
        if (rf_resp !== {2'b11, 32'h0, 2'b11, 32'h0}) begin
            tests_failed++;
            $display("FAIL x0_same_cycle: got %h expected both valid zero", rf_resp);
        end
        do_lookup(6'd0, 6'd0);
        tests_run++;
        if (rf_resp !== {2'b11, 32'h0, 2'b11, 32'h0}) begin
            tests_failed++;
            $display("FAIL x0_after: got %h expected both valid zero", rf_resp);
        end
    endtask

    task automatic test_bypass();
        do_rename(5'd7, 5'd11);
        idle();
        iq_req.lookup_regfile_1 = 1'b1; iq_req.reg_idx_1 = 6'd7;
        iq_req.lookup_regfile_2 = 1'b1; iq_req.reg_idx_2 = 6'd39;
        commit_valid = 1'b1; commit_rd = 5'd7; commit_rob = 5'd11; commit_val = 32'h1234;
        step();
        tests_run++;
        if (rf_resp !== {2'b11, 32'h1234, 2'b11, 32'h1234}) begin
            tests_failed++;
            $display("FAIL commit_bypass: got %h expected both valid 1234", rf_resp);
        end
    endtask

    task automatic test_commit_rename_same();
        do_rename(5'd8, 5'd1);
        idle();
        commit_valid = 1'b1; commit_rd = 5'd8; commit_rob = 5'd1; commit_val = 32'h77;
        iq_req.write = 1'b1; iq_req.rd = 5'd8; iq_req.rob_index = 5'd12;
        step();
        do_lookup(6'd8, 6'd8);
        tests_run++;
        if (rf_resp.valid_1 !== 1'b0 || rf_resp.val_1 !== 32'd12 || rf_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL commit_rename_same: got %h expected %h (busy tag 12)", rf_resp, exp_resp);
        end
        do_commit(5'd8, 5'd12, 32'h99);
        do_lookup(6'd8, 6'd1);
        tests_run++;
        if (rf_resp.val_1 !== 32'h99 || rf_resp !== exp_resp) begin
            tests_failed++;
            $display("FAIL commit_rename_value: got %h expected %h", rf_resp, exp_resp);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 59) == 0);
            iq_req.write = $urandom_range(0, 1);
            iq_req.rd = 5'($urandom_range(0, 7));
            iq_req.rob_index = 5'($urandom);
            iq_req.lookup_regfile_1 = ($urandom_range(0, 3) != 0);
            iq_req.reg_idx_1 = {1'($urandom), 5'($urandom_range(0, 7))};
            iq_req.lookup_regfile_2 = ($urandom_range(0, 3) != 0);
            iq_req.reg_idx_2 = {1'($urandom), 5'($urandom_range(0, 7))};
            rob_ctrl.flush_all = ($urandom_range(0, 15) == 0);
            rob_ctrl.target_pc = $urandom;
            commit_valid = $urandom_range(0, 1);
            commit_rd = 5'($urandom_range(0, 7));
            commit_rob = ($urandom_range(0, 2) != 0) ? m_tag[commit_rd] : 5'($urandom);
            commit_val = $urandom;
            step();
            tests_run++;
            if (rf_resp !== exp_resp) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle_%0d: got %h expected %h", n, rf_resp, exp_resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_rename(5'd3, 5'd4);
        do_commit(5'd5, 5'd0, 32'hCAFE);
        idle();
        rst = 1'b1;
        iq_req.lookup_regfile_1 = 1'b1; iq_req.reg_idx_1 = 6'd5;
        iq_req.lookup_regfile_2 = 1'b1; iq_req.reg_idx_2 = 6'd3;
        iq_req.write = 1'b1; iq_req.rd = 5'd6; iq_req.rob_index = 5'd2;
        step();
        tests_run++;
        if (rf_resp !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_resp: got %h expected 0", rf_resp);
        end
        do_lookup(6'd3, 6'd6);
        tests_run++;
        if (rf_resp !== {2'b11, 32'h0, 2'b11, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_mid_state: got %h expected both valid zero", rf_resp);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_rename_lookup();
        test_commit();
        test_stale_commit();
        test_flush();
        test_x0();
        test_bypass();
        test_commit_rename_same();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 SHALL have parameter ZERO_HARDWIRED, default 1: x0 reads 0, is never busy, and ignores writes and commits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port iq_req, input, sched_structs::IQtoRF: issue-queue rename write and two source lookups.
REQ-005 SHALL have port rf_resp, output, sched_structs::RFtoIQ: registered lookup responses.
REQ-006 SHALL have port rob_ctrl, input, sched_structs::ROBToALL: flush_all used; target_pc ignored.
REQ-007 SHALL have port commit_valid, input, 1: ROB retires an instruction that writes a register this cycle.
REQ-008 SHALL have port commit_rd, input, 5: architectural destination of the retiring instruction.
REQ-009 SHALL have port commit_rob, input, 5: ROB index of the retiring instruction.
REQ-010 SHALL have port commit_val, input, 32: result value being retired.

Function
REQ-011 SHALL hold 32 entries, each {value[31:0], busy, tag[4:0]}.
REQ-012 SHALL use reg_idx_N[4:0] as the register index; reg_idx_N[5] is ignored.
REQ-013 Rename: when iq_req.write=1 and rd!=0, the entry at rd SHALL get busy=1 and tag=rob_index at the clock edge.
REQ-014 Commit: when commit_valid=1 and commit_rd!=0, the entry at commit_rd SHALL take value=commit_val at the edge.
REQ-015 On commit, busy SHALL clear only if tag==commit_rob; otherwise busy and tag are unchanged.
REQ-016 Lookup latency SHALL be 1 cycle: lookup_valid_N is the registered copy of lookup_regfile_N.
REQ-017 Response for a non-busy register SHALL be valid_N=1 and val_N=the stored value.
REQ-018 Response for a busy register SHALL be valid_N=0 and val_N={27'b0, tag}.
REQ-019 When lookup_regfile_N=0, the registered valid_N and val_N SHALL be 0.
REQ-020 Lookup plus rename of the same register in the same cycle: the lookup SHALL see the pre-rename state, so a source never depends on its own instruction.
REQ-021 Lookup plus commit of the same busy register whose tag==commit_rob in the same cycle SHALL bypass: valid_N=1, val_N=commit_val.
REQ-022 Commit and rename of the same register in the same cycle: value SHALL be written, and busy=1 with the new rename tag SHALL win.
REQ-023 A lookup of x0 SHALL always return valid_N=1 and val_N=0.
REQ-024 When rob_ctrl.flush_all=1, every busy bit SHALL clear at the edge.
REQ-025 During a flush, values SHALL be retained, and a commit in the same cycle still writes its value.
REQ-026 During a flush, a same-cycle rename SHALL be dropped.
REQ-027 During a flush, the next-cycle lookup_valid_1 and lookup_valid_2 SHALL be 0.
REQ-028 The two lookup ports SHALL be independent, and both may address the same register.

Reset
REQ-029 On rst=1, all values SHALL become 0, all busy bits 0, all tags 0, and rf_resp all-zero on the following cycle.
REQ-030 rst SHALL override rename, commit, flush and lookup in the same cycle.
REQ-031 rst asserted mid-operation SHALL discard all in-flight lookup responses.

Verification
REQ-032 Reset, then look up x5 on port 1 -> next cycle lookup_valid_1=1, valid_1=1, val_1=0.
REQ-033 Rename x3 to ROB 7; next cycle look up x3 -> valid=0, val=7.
REQ-034 Commit x3 with rob 7 and value 0xDEADBEEF -> x3 reads valid=1, val=0xDEADBEEF.
REQ-035 Rename x3 to ROB 7, then rename x3 to ROB 9; commit rob 7 with value 0x11 -> x3 stays busy, val=9.
REQ-036 Rename x3 and x4; then in one cycle assert lookup x3, commit x3 (tag match, value 0x22) and flush_all -> lookup_valid=0 next cycle; afterwards x3=0x22 valid and x4 shows its old value valid.
REQ-037 In one cycle, rename x0, commit x0 with 0x55, and look up x0 on both ports -> valid_1=valid_2=1 and val=0; x0 is never busy.
